// File: rtl/game_controller_pkg.sv
// Shared state encodings, field widths and small helpers for the snake game-flow logic.
package game_controller_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    INIT = 2'd1,
    PLAY = 2'd2,
    OVER = 2'd3
  } state_t;

  localparam int LEN_W = 5;
  localparam int PER_W = 4;

  // One frame faster, but never below the floor.
  function automatic logic [PER_W-1:0] dec_floor(input logic [PER_W-1:0] p,
                                                 input logic [PER_W-1:0] floor);
    return (p > floor) ? (p - 4'd1) : p;
  endfunction

endpackage

// File: rtl/game_controller_step_timer.sv
// Frame counter, step period and speed sub-counter. step is the combinational wrap
// strobe; the parent registers it, so snake_step lands one cycle after the frame_tick.
module step_timer
  import game_controller_pkg::*;
#(
  parameter int TICK_BASE  = 8,
  parameter int TICK_MIN   = 2,
  parameter int SCORE_STEP = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             frame_tick,
  input  logic             run,
  input  logic             clear,
  input  logic             speedup,
  output logic             step,
  output logic [PER_W-1:0] period
);

  localparam int SUB_W = (SCORE_STEP > 1) ? $clog2(SCORE_STEP + 1) : 1;
  localparam logic [PER_W-1:0] BASE     = PER_W'(TICK_BASE);
  localparam logic [PER_W-1:0] FLOOR    = PER_W'(TICK_MIN);
  localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(SCORE_STEP - 1);

  logic [PER_W-1:0] count;
  logic [SUB_W-1:0] sub;

  // ">=" so that a count left above a freshly shortened period wraps on the next tick.
  assign step = run & frame_tick & (count >= (period - 4'd1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count  <= '0;
      sub    <= '0;
      period <= BASE;
    end else if (clear) begin
      count  <= '0;
      sub    <= '0;
      period <= BASE;
    end else begin
      if (run && frame_tick) begin
        count <= step ? '0 : (count + 4'd1);
      end
      if (run && speedup) begin
        if (sub == SUB_LAST) begin
          sub    <= '0;
          period <= dec_floor(period, FLOOR);
        end else begin
          sub <= sub + SUB_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/game_controller.sv
// Game-flow sequencer for the snake top level: idle/init/play/over phases, step pulses,
// growth, score and the apple-respawn handshake.
module game_controller
  import game_controller_pkg::*;
#(
  parameter int TICK_BASE   = 8,
  parameter int TICK_MIN    = 2,
  parameter int SCORE_STEP  = 4,
  parameter int SCORE_W     = 8,
  parameter int INIT_LEN    = 3,
  parameter int MAX_LEN     = 16,
  parameter int OVER_FRAMES = 120
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               frame_tick,
  input  logic               btn_any,
  input  logic               hit_wall,
  input  logic               hit_self,
  input  logic               apple_eaten,
  input  logic               apple_pos_valid,
  output logic               apple_req,
  output logic               snake_init,
  output logic               snake_step,
  output logic               snake_grow,
  output logic               game_active,
  output logic               game_over,
  output logic [SCORE_W-1:0] score,
  output logic [LEN_W-1:0]   length,
  output logic [PER_W-1:0]   period
);

  localparam int OVER_W = $clog2(OVER_FRAMES + 1);
  localparam logic [OVER_W-1:0]  OVER_LAST = OVER_W'(OVER_FRAMES - 1);
  localparam logic [SCORE_W-1:0] SCORE_MAX = '1;
  localparam logic [LEN_W-1:0]   LEN_INIT  = LEN_W'(INIT_LEN);
  localparam logic [LEN_W-1:0]   LEN_MAX   = LEN_W'(MAX_LEN);

  state_t            state, state_next;
  logic              btn_prev;
  logic              grow_pending;
  logic [OVER_W-1:0] over_cnt;
  logic              collision, in_play, start, apple_ok, run, over_done, timer_step, grows;

  assign collision = hit_wall | hit_self;
  assign in_play   = (state == PLAY);
  assign start     = (state == IDLE) & btn_any & ~btn_prev;
  // A collision suppresses the apple and any step in the same cycle.
  assign apple_ok  = in_play & apple_eaten & ~collision;
  assign run       = in_play & ~collision;
  assign over_done = (state == OVER) & frame_tick & (over_cnt == OVER_LAST);
  assign grows     = timer_step & (grow_pending | apple_ok) & (length < LEN_MAX);

  step_timer #(
    .TICK_BASE (TICK_BASE),
    .TICK_MIN  (TICK_MIN),
    .SCORE_STEP(SCORE_STEP)
  ) u_step_timer (
    .clk       (clk),
    .reset     (reset),
    .frame_tick(frame_tick),
    .run       (run),
    .clear     (start),
    .speedup   (apple_ok),
    .step      (timer_step),
    .period    (period)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = INIT; else state_next = IDLE;
      INIT:    state_next = PLAY;
      PLAY:    if (collision) state_next = OVER; else state_next = PLAY;
      OVER:    if (over_done) state_next = IDLE; else state_next = OVER;
      default: state_next = IDLE;
    endcase
  end

  // Phase levels are registered from the next state so they align with the state itself.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      btn_prev     <= 1'b0;
      snake_init   <= 1'b0;
      game_active  <= 1'b0;
      game_over    <= 1'b0;
      snake_step   <= 1'b0;
      snake_grow   <= 1'b0;
      over_cnt     <= '0;
      score        <= '0;
      length       <= '0;
      grow_pending <= 1'b0;
      apple_req    <= 1'b0;
    end else begin
      btn_prev    <= btn_any;
      snake_init  <= (state_next == INIT);
      game_active <= (state_next == PLAY);
      game_over   <= (state_next == OVER);
      snake_step  <= timer_step;
      snake_grow  <= grows;

      if (state != OVER)   over_cnt <= '0;
      else if (frame_tick) over_cnt <= over_cnt + OVER_W'(1);

      if (start) begin
        score        <= '0;
        length       <= LEN_INIT;
        grow_pending <= 1'b0;
        apple_req    <= 1'b1;
      end else begin
        if (apple_ok && (score != SCORE_MAX)) score <= score + SCORE_W'(1);
        if (grows) length <= length + LEN_W'(1);
        if (timer_step)    grow_pending <= 1'b0;
        else if (apple_ok) grow_pending <= 1'b1;
        if (state == OVER)        apple_req <= 1'b0;
        else if (apple_ok)        apple_req <= 1'b1;
        else if (apple_pos_valid) apple_req <= 1'b0;
      end
    end
  end

endmodule
